// File: rtl/mem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter_if
// Brief    : Request/grant bundle between requestors and mem_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [CNT_W-1:0]   burst_cnt;
    logic               arbiter_state;

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_valid,
        output grant_id,
        output burst_cnt,
        output arbiter_state
    );

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  burst_cnt,
        input  arbiter_state
    );
endinterface
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Brief    : Round-robin burst arbiter for a shared memory port, with
//            zero-bubble owner handoff, binary grant ID and debug status.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_rr_arbiter_if.slave     bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [ID_W-1:0]  C_LAST = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state,     w_state_n;
    logic [NUM_REQ-1:0] r_grant,     w_grant_n;
    logic [ID_W-1:0]    r_grant_id,  w_grant_id_n;
    logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_n;
    logic [ID_W-1:0]    r_last_ptr,  w_last_ptr_n;

    logic [NUM_REQ-1:0] w_cand;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_win;
    logic               w_found;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_owner_done;
    logic               w_owner_req;
    logic               w_others;
    logic               w_release;

    // Circular scan starting one past the last owner; while granted the
    // current owner is masked out so a release hands off to someone else.
    always_comb begin
        w_cand  = (r_state == S_GRANT) ? (bus.req & ~r_grant) : bus.req;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_last_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (w_idx == C_LAST) ? '0 : w_idx + ID_W'(1);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_oh     = NUM_REQ'(1) << w_win;
    assign w_owner_done = |(bus.done & r_grant);
    assign w_owner_req  = |(bus.req  & r_grant);
    assign w_others     = |(bus.req  & ~r_grant);
    assign w_release    = w_owner_done || !w_owner_req ||
                          ((r_burst_cnt == C_MAX) && w_others);

    always_comb begin
        w_state_n     = r_state;
        w_grant_n     = r_grant;
        w_grant_id_n  = r_grant_id;
        w_burst_cnt_n = r_burst_cnt;
        w_last_ptr_n  = r_last_ptr;
        case (r_state)
            S_IDLE: begin
                w_grant_n = '0;
                if (w_found) begin
                    w_state_n     = S_GRANT;
                    w_grant_n     = w_win_oh;
                    w_grant_id_n  = w_win;
                    w_burst_cnt_n = C_ONE;
                    w_last_ptr_n  = w_win;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    if (w_found) begin
                        w_grant_n     = w_win_oh;
                        w_grant_id_n  = w_win;
                        w_burst_cnt_n = C_ONE;
                        w_last_ptr_n  = w_win;
                    end else begin
                        w_state_n     = S_IDLE;
                        w_grant_n     = '0;
                        w_burst_cnt_n = '0;
                    end
                end else if (r_burst_cnt != C_MAX) begin
                    w_burst_cnt_n = r_burst_cnt + C_ONE;
                end
            end
            default: begin
                w_state_n     = S_IDLE;
                w_grant_n     = '0;
                w_burst_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
            r_last_ptr  <= C_LAST;
        end else begin
            r_state     <= w_state_n;
            r_grant     <= w_grant_n;
            r_grant_id  <= w_grant_id_n;
            r_burst_cnt <= w_burst_cnt_n;
            r_last_ptr  <= w_last_ptr_n;
        end
    end

    assign bus.grant         = r_grant;
    assign bus.grant_valid   = (r_state == S_GRANT);
    assign bus.grant_id      = r_grant_id;
    assign bus.burst_cnt     = r_burst_cnt;
    assign bus.arbiter_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rr_arbiter
// Brief    : Directed self-checking bench for mem_rr_arbiter (4 req, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_rr_arbiter_if #(.NUM_REQ(4), .MAX_BURST(4)) bus ();

    mem_rr_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {grant[3:0], grant_valid, grant_id[1:0], burst_cnt[2:0], arbiter_state}
    logic [10:0] obs;
    assign obs = {bus.grant, bus.grant_valid, bus.grant_id, bus.burst_cnt, bus.arbiter_state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 11'b0000_0_00_000_0) begin
            errors++; $display("FAIL reset_state: got %b want %b", obs, 11'b0000_0_00_000_0);
        end
    endtask

    task automatic test_sole_owner();
        logic [2:0] cnt_exp [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        bus.req = 4'b0001;
        checks++;
        if (bus.grant !== 4'b0000) begin
            errors++; $display("FAIL latency_before_edge: got %b want %b", bus.grant, 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== {4'b0001, 1'b1, 2'd0, cnt_exp[i], 1'b1}) begin
                errors++; $display("FAIL sole_burst[%0d]: got %b want %b", i, obs, {4'b0001, 1'b1, 2'd0, cnt_exp[i], 1'b1});
            end
        end
        tick();
        checks++;
        if (obs !== {4'b0001, 1'b1, 2'd0, 3'd4, 1'b1}) begin
            errors++; $display("FAIL sole_saturate: got %b want %b", obs, {4'b0001, 1'b1, 2'd0, 3'd4, 1'b1});
        end
    endtask

    task automatic test_burst_limit();
        logic [3:0] g_exp  [3] = '{4'b0010, 4'b0100, 4'b0001};
        logic [1:0] id_exp [3] = '{2'd1, 2'd2, 2'd0};
        bus.req = 4'b0111;
        for (int o = 0; o < 3; o++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                checks++;
                if (obs !== {g_exp[o], 1'b1, id_exp[o], 3'(c), 1'b1}) begin
                    errors++; $display("FAIL burst_limit[%0d][%0d]: got %b want %b", o, c, obs, {g_exp[o], 1'b1, id_exp[o], 3'(c), 1'b1});
                end
                if (o == 2) break;
            end
        end
    endtask

    task automatic test_done_release();
        do_reset();
        bus.req = 4'b0010;
        tick();
        checks++;
        if (obs !== {4'b0010, 1'b1, 2'd1, 3'd1, 1'b1}) begin
            errors++; $display("FAIL done_setup: got %b want %b", obs, {4'b0010, 1'b1, 2'd1, 3'd1, 1'b1});
        end
        bus.req  = 4'b1011;
        bus.done = 4'b0010;
        tick();
        checks++;
        if (obs !== {4'b1000, 1'b1, 2'd3, 3'd1, 1'b1}) begin
            errors++; $display("FAIL done_handoff: got %b want %b", obs, {4'b1000, 1'b1, 2'd3, 3'd1, 1'b1});
        end
        bus.req  = 4'b1000;
        bus.done = 4'b1000;
        tick();
        checks++;
        if (obs !== {4'b0000, 1'b0, 2'd3, 3'd0, 1'b0}) begin
            errors++; $display("FAIL done_to_idle: got %b want %b", obs, {4'b0000, 1'b0, 2'd3, 3'd0, 1'b0});
        end
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.req = 4'b1111;
        tick();
        checks++;
        if (obs !== {ord[0], 1'b1, ids[0], 3'd1, 1'b1}) begin
            errors++; $display("FAIL rr_order[0]: got %b want %b", obs, {ord[0], 1'b1, ids[0], 3'd1, 1'b1});
        end
        for (int i = 1; i < 5; i++) begin
            bus.done = ord[i-1];
            tick();
            checks++;
            if (obs !== {ord[i], 1'b1, ids[i], 3'd1, 1'b1}) begin
                errors++; $display("FAIL rr_order[%0d]: got %b want %b", i, obs, {ord[i], 1'b1, ids[i], 3'd1, 1'b1});
            end
        end
        bus.done = 4'b0100;
        tick();
        checks++;
        if (obs !== {4'b0001, 1'b1, 2'd0, 3'd2, 1'b1}) begin
            errors++; $display("FAIL nonowner_done: got %b want %b", obs, {4'b0001, 1'b1, 2'd0, 3'd2, 1'b1});
        end
        bus.done = 4'b0000;
    endtask

    task automatic test_async_reset(input logic [3:0] req_after, input logic [3:0] g_want, input logic [1:0] id_want);
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        checks++;
        if (obs !== {4'b0100, 1'b1, 2'd2, 3'd2, 1'b1}) begin
            errors++; $display("FAIL midburst_setup: got %b want %b", obs, {4'b0100, 1'b1, 2'd2, 3'd2, 1'b1});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 11'b0000_0_00_000_0) begin
            errors++; $display("FAIL async_reset_drop: got %b want %b", obs, 11'b0000_0_00_000_0);
        end
        bus.req = req_after;
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== {g_want, 1'b1, id_want, 3'd1, 1'b1}) begin
            errors++; $display("FAIL ptr_after_reset: got %b want %b", obs, {g_want, 1'b1, id_want, 3'd1, 1'b1});
        end
    endtask

    task automatic test_req_swap();
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b1000;
        tick();
        checks++;
        if (obs !== {4'b1000, 1'b1, 2'd3, 3'd1, 1'b1}) begin
            errors++; $display("FAIL req_swap: got %b want %b", obs, {4'b1000, 1'b1, 2'd3, 3'd1, 1'b1});
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (obs !== {4'b0000, 1'b0, 2'd3, 3'd0, 1'b0}) begin
            errors++; $display("FAIL req_drop_idle: got %b want %b", obs, {4'b0000, 1'b0, 2'd3, 3'd0, 1'b0});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        test_reset();
        test_sole_owner();
        test_burst_limit();
        test_done_release();
        test_back_to_back();
        test_async_reset(4'b0101, 4'b0001, 2'd0);
        test_async_reset(4'b1100, 4'b0100, 2'd2);
        test_req_swap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Parametrised round-robin memory arbiter for NUM_REQ requestors, placed in front of the shared memory port.
- Each grant is held for a burst until the owner releases it or the burst limit expires while others wait.
- Provides back-to-back handoff with no idle cycle, plus a binary grant ID and debug status.

Parameters:
- NUM_REQ, 4, number of requestors (>=2).
- MAX_BURST, 8, max cycles one owner keeps the grant while another requestor is pending (>=1).
- ID_W, $clog2(NUM_REQ), width of grant_id (derived, min 1).
- CNT_W, $clog2(MAX_BURST+1), width of burst_cnt (derived).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requestor request level.
- done  input  NUM_REQ  per-requestor release pulse; only the owner's bit is honoured.
- grant  output  NUM_REQ  one-hot grant, registered; all-zero when idle.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  ID_W  index of the current owner; holds its last value when idle.
- burst_cnt  output  CNT_W  cycles the current owner has held the grant, saturating.
- arbiter_state  output  1  debug: 0=IDLE, 1=GRANT.

Behaviour:
- Reset (async): grant=0, grant_valid=0, grant_id=0, burst_cnt=0, arbiter_state=IDLE.
- Reset also sets the internal last-owner pointer to NUM_REQ-1, so req[0] has first priority after reset.
- All outputs are registered and change only on the rising edge of clk (or on reset).
- Round-robin pick with mask M: the first set bit of (req & M), scanning circularly from last_ptr+1 to last_ptr. last_ptr is updated to the new owner on every grant.
- IDLE:
  - If req != 0: pick with M = all ones; next cycle assert the grant, set state=GRANT, burst_cnt=1.
  - Latency from req to grant is exactly 1 cycle.
  - Else: stay IDLE, outputs unchanged except grant=0.
- GRANT, owner k. Release occurs when any of these holds:
  - (a) done[k]=1
  - (b) req[k]=0
  - (c) burst_cnt==MAX_BURST and (req & ~bit k) != 0
- On release:
  - Pick with M = ~bit k.
  - If a winner j exists: grant switches directly k->j on the same edge, burst_cnt=1, state stays GRANT (no bubble).
  - If no winner: grant=0, grant_valid=0, state=IDLE, burst_cnt=0.
- No release: the grant is held; burst_cnt increments and saturates at MAX_BURST.
  - An owner alone on the bus keeps the grant indefinitely.
- done on a non-owner bit is ignored. done and req deassert in the same cycle count as a single release.
- Simultaneous release and new requests: arbitration uses the req value sampled on that same edge.
- A requestor dropping req before it is granted loses its place; there is no request latching.
- Exactly one grant bit is ever high; grant_id always equals the index of that bit while grant_valid=1.
- Reset mid-burst: grant drops immediately (async) and the priority pointer returns to NUM_REQ-1.

Test Plan (NUM_REQ=4, MAX_BURST=4):
- Reset, then req=0001 -> next cycle grant=0001, grant_id=0, burst_cnt=1. Hold req -> burst_cnt 2,3,4,4 and grant held (sole requestor).
- Owner 0 holding, req=0111 steady, no done -> after burst_cnt=4, next edge grant=0010. After 4 more cycles grant=0100, then grant=0001. No idle cycle between owners.
- Owner 1, pulse done[1] with req=1011 -> next edge grant=1000 (search starts at 2; bit 2 clear). Pulse done[3] with only req[3] still high -> grant=0000, state IDLE.
- req=1111 from reset, each owner pulses done after 1 cycle -> grant order 0001,0010,0100,1000,0001. Pulse done[2] while owner is 0 -> no effect.
- Owner 2 mid-burst (burst_cnt=2), assert reset asynchronously -> grant=0 immediately. After release with req=0101 -> grant=0001 (pointer reset).
- Owner 0, req[0] drops and req[3] rises in the same cycle -> next edge grant=1000, burst_cnt=1.
